// File: rtl/gfdiv_seq_if.sv
// Handshake and operand bundle for the sequential GF(2^m) divider.
// master: requester side (drives start/operands); slave: the divider.
interface gfdiv_seq_if #(
  parameter int W = 4
);
  logic         start;
  logic [2:0]   m;
  logic [W:0]   p;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic         dz;
  logic         cfg_err;
  logic         chk_fail;

  modport master (
    output start, m, p, a, b,
    input  busy, done, quo, dz, cfg_err, chk_fail
  );

  modport slave (
    input  start, m, p, a, b,
    output busy, done, quo, dz, cfg_err, chk_fail
  );
endinterface

// File: rtl/gfdiv_seq.sv
// Sequential GF(2^m) divider: quo = a * b^-1 mod p, 2 <= m <= W.
// The inverse is b^(2^m-2), built by m-1 square-and-multiply steps.
// Optional macro GFDIV_SELFCHK_EN adds a CHK state that multiplies the
// quotient back by b and flags chk_fail on mismatch with a.
module gfdiv_seq #(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  gfdiv_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ITER = 3'd1,
    ST_FIN  = 3'd2,
    ST_CHK  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Carry-less product of two m-bit values, reduced MSB-first by p.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic [2:0]   mm,
                                          input logic [W:0]   pp);
    logic [2*W-2:0] prod;
    logic [2*W-2:0] poly;
    prod = '0;
    poly = {{(W-2){1'b0}}, pp};
    for (int i = 0; i < W; i++) begin
      if (y[i]) prod = prod ^ ({{(W-1){1'b0}}, x} << i);
    end
    for (int i = 2*W-2; i >= 0; i--) begin
      if ((i >= int'(mm)) && prod[i]) prod = prod ^ (poly << (i - int'(mm)));
    end
    return prod[W-1:0];
  endfunction

  // Ones in the low m bit positions; operand bits at or above m are dropped.
  function automatic logic [W-1:0] field_mask(input logic [2:0] mm);
    logic [W-1:0] msk;
    for (int i = 0; i < W; i++) msk[i] = (i < int'(mm));
    return msk;
  endfunction

  state_t       state_q, state_d;
  logic [2:0]   m_q, m_d;
  logic [W:0]   p_q, p_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] r_q, r_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [1:0]   errk_q, errk_d;   // [1] config error, [0] divide by zero
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] quo_q, quo_d;
  logic         dz_q, dz_d;
  logic         cfg_err_q, cfg_err_d;
`ifdef GFDIV_SELFCHK_EN
  logic [W-1:0] b_q, b_d;
  logic         chk_fail_q, chk_fail_d;
`endif

  logic [W-1:0] in_mask_s;
  logic [W-1:0] b_in_s;
  logic         cfg_bad_s;
  logic [W-1:0] sq_s;

  assign in_mask_s = field_mask(bus.m);
  assign b_in_s    = bus.b & in_mask_s;
  assign cfg_bad_s = (int'(bus.m) < 2) || (int'(bus.m) > W);
  assign sq_s      = gf_mul(s_q, s_q, m_q, p_q);

  // State and datapath registers; async reset clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      m_q        <= 3'd0;
      p_q        <= '0;
      a_q        <= '0;
      s_q        <= '0;
      r_q        <= '0;
      cnt_q      <= 3'd0;
      errk_q     <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      dz_q       <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef GFDIV_SELFCHK_EN
      b_q        <= '0;
      chk_fail_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      p_q        <= p_d;
      a_q        <= a_d;
      s_q        <= s_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      errk_q     <= errk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      dz_q       <= dz_d;
      cfg_err_q  <= cfg_err_d;
`ifdef GFDIV_SELFCHK_EN
      b_q        <= b_d;
      chk_fail_q <= chk_fail_d;
`endif
    end
  end

  // Next-state and datapath update; done is a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    p_d        = p_q;
    a_d        = a_q;
    s_d        = s_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    errk_d     = errk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quo_d      = quo_q;
    dz_d       = dz_q;
    cfg_err_d  = cfg_err_q;
`ifdef GFDIV_SELFCHK_EN
    b_d        = b_q;
    chk_fail_d = chk_fail_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          m_d       = bus.m;
          p_d       = bus.p;
          a_d       = bus.a & in_mask_s;
          s_d       = b_in_s;
          r_d       = {{(W-1){1'b0}}, 1'b1};
          cnt_d     = 3'd0;
          busy_d    = 1'b1;
          dz_d      = 1'b0;
          cfg_err_d = 1'b0;
`ifdef GFDIV_SELFCHK_EN
          b_d        = b_in_s;
          chk_fail_d = 1'b0;
`endif
          if (cfg_bad_s) begin
            errk_d  = 2'b10;
            state_d = ST_ERR;
          end else if (b_in_s == '0) begin
            errk_d  = 2'b01;
            state_d = ST_ERR;
          end else begin
            errk_d  = 2'b00;
            state_d = ST_ITER;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        // After step i: s = b^(2^i), r = prod_{j=1..i} b^(2^j)
        s_d   = sq_s;
        r_d   = gf_mul(r_q, sq_s, m_q, p_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == (m_q - 3'd2)) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_FIN: begin
        quo_d = gf_mul(a_q, r_q, m_q, p_q);
`ifdef GFDIV_SELFCHK_EN
        state_d = ST_CHK;
`else
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`endif
      end
      ST_CHK: begin
`ifdef GFDIV_SELFCHK_EN
        chk_fail_d = (gf_mul(quo_q, b_q, m_q, p_q) != a_q);
        done_d     = 1'b1;
`endif
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        quo_d     = '0;
        cfg_err_d = errk_q[1];
        dz_d      = errk_q[0] & ~errk_q[1];
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.quo     = quo_q;
  assign bus.dz      = dz_q;
  assign bus.cfg_err = cfg_err_q;
`ifdef GFDIV_SELFCHK_EN
  assign bus.chk_fail = chk_fail_q;
`else
  assign bus.chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_gfdiv_seq.sv
// Self-checking bench for gfdiv_seq: vector table, exhaustive m=4 sweep with
// back-to-back starts, start-while-busy and mid-operation reset sequences.
module tb_gfdiv_seq;

  localparam int W = 4;
`ifdef GFDIV_SELFCHK_EN
  localparam int XLAT = 1;
`else
  localparam int XLAT = 0;
`endif

  typedef struct {
    logic [2:0] m;
    logic [4:0] p;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] quo;
    logic       dz;
    logic       cfg;
    int         lat;
  } vec_t;

  typedef struct {
    logic [3:0] quo;
    logic       dz;
    logic       cfg;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  vec_t vecs[8];

  gfdiv_seq_if #(.W(W)) bus ();

  gfdiv_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] mdl_mul(input logic [3:0] x, input logic [3:0] y,
                                         input int mm, input logic [4:0] pp);
    logic [4:0] acc;
    logic [4:0] sh;
    acc = 5'd0;
    sh  = {1'b0, x};
    for (int i = 0; i < mm; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = sh << 1;
      if (sh[mm]) sh = sh ^ pp;
    end
    return acc[3:0];
  endfunction

  function automatic logic [3:0] mdl_div(input logic [3:0] a, input logic [3:0] b,
                                         input int mm, input logic [4:0] pp);
    logic [3:0] q;
    logic [3:0] res;
    res = 4'd0;
    for (int i = 0; i < (1 << mm); i++) begin
      q = 4'(i);
      if (mdl_mul(q, b, mm, pp) == a) res = q;
    end
    return res;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drive one request (start high) and register its expected result.
  task automatic issue(input logic [2:0] m, input logic [4:0] p, input logic [3:0] a,
                       input logic [3:0] b, input exp_t e);
    bus.m     = m;
    bus.p     = p;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    sb.push_back(e);
  endtask

  // Pass the sampling edge E0 and drop start.
  task automatic go_e0();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_e0", int'(bus.busy), 1);
  endtask

  // Count edges from lat0 until done, then pop and compare the scoreboard.
  task automatic wait_done(input int lat0, input string tag);
    int   lat;
    bit   got;
    exp_t e;
    lat = lat0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"}, lat, e.lat);
      check({tag, "_quo"}, int'(bus.quo), int'(e.quo));
      check({tag, "_dz"}, int'(bus.dz), int'(e.dz));
      check({tag, "_cfg"}, int'(bus.cfg_err), int'(e.cfg));
      check({tag, "_chk"}, int'(bus.chk_fail), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
    end
  endtask

  initial begin
    exp_t e;
    int   nd;
    n_tests = 0;
    n_fail  = 0;
    bus.start = 1'b0;
    bus.m = 3'd0;
    bus.p = 5'd0;
    bus.a = 4'd0;
    bus.b = 4'd0;

    vecs[0] = '{m: 3'd4, p: 5'b10011, a: 4'h1, b: 4'h2, quo: 4'h9, dz: 1'b0, cfg: 1'b0, lat: 4 + XLAT};
    vecs[1] = '{m: 3'd3, p: 5'b01011, a: 4'h3, b: 4'h2, quo: 4'h4, dz: 1'b0, cfg: 1'b0, lat: 3 + XLAT};
    vecs[2] = '{m: 3'd3, p: 5'b01011, a: 4'hB, b: 4'h2, quo: 4'h4, dz: 1'b0, cfg: 1'b0, lat: 3 + XLAT};
    vecs[3] = '{m: 3'd3, p: 5'b01011, a: 4'h3, b: 4'hA, quo: 4'h4, dz: 1'b0, cfg: 1'b0, lat: 3 + XLAT};
    vecs[4] = '{m: 3'd4, p: 5'b10011, a: 4'h7, b: 4'h0, quo: 4'h0, dz: 1'b1, cfg: 1'b0, lat: 1};
    vecs[5] = '{m: 3'd5, p: 5'b10011, a: 4'h1, b: 4'h2, quo: 4'h0, dz: 1'b0, cfg: 1'b1, lat: 1};
    vecs[6] = '{m: 3'd1, p: 5'b00011, a: 4'h1, b: 4'h0, quo: 4'h0, dz: 1'b0, cfg: 1'b1, lat: 1};
    vecs[7] = '{m: 3'd2, p: 5'b00111, a: 4'h1, b: 4'h2, quo: 4'h3, dz: 1'b0, cfg: 1'b0, lat: 2 + XLAT};

    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_quo", int'(bus.quo), 0);
    check("rst_flags", int'({bus.dz, bus.cfg_err, bus.chk_fail}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = '{quo: vecs[i].quo, dz: vecs[i].dz, cfg: vecs[i].cfg, lat: vecs[i].lat};
      issue(vecs[i].m, vecs[i].p, vecs[i].a, vecs[i].b, e);
      go_e0();
      wait_done(0, $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), int'(bus.done), 0);
      check($sformatf("vec%0d_quo_hold", i), int'(bus.quo), int'(vecs[i].quo));
    end

    // Exhaustive m=4 sweep, each start issued while the previous done is high
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        e = '{quo: mdl_div(4'(a), 4'(b), 4, 5'b10011), dz: 1'b0, cfg: 1'b0, lat: 4 + XLAT};
        issue(3'd4, 5'b10011, 4'(a), 4'(b), e);
        go_e0();
        wait_done(0, $sformatf("ex_a%0d_b%0d", a, b));
        check($sformatf("ex_a%0d_b%0d_inv", a, b),
              int'(mdl_mul(bus.quo, 4'(b), 4, 5'b10011)), a);
      end
    end
    @(posedge clk);
    #1;
    check("ex_done_pulse", int'(bus.done), 0);

    // start pulsed while busy is ignored
    @(negedge clk);
    e = '{quo: 4'h9, dz: 1'b0, cfg: 1'b0, lat: 4 + XLAT};
    issue(3'd4, 5'b10011, 4'h1, 4'h2, e);
    go_e0();
    bus.m = 3'd3;
    bus.p = 5'b01011;
    bus.a = 4'h5;
    bus.b = 4'h3;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(2, "busy_start");
    nd = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) nd++;
    end
    check("busy_start_no_queue", nd, 0);
    check("busy_start_quo_hold", int'(bus.quo), 9);

    // reset asserted at E2 aborts the operation
    @(negedge clk);
    e = '{quo: 4'h9, dz: 1'b0, cfg: 1'b0, lat: 4 + XLAT};
    issue(3'd4, 5'b10011, 4'h1, 4'h2, e);
    go_e0();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", int'(bus.busy), 0);
    check("abort_quo", int'(bus.quo), 0);
    check("abort_done", int'(bus.done), 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) nd++;
    end
    check("abort_no_done", nd, 0);

    // divider still works after the abort
    @(negedge clk);
    e = '{quo: 4'h4, dz: 1'b0, cfg: 1'b0, lat: 3 + XLAT};
    issue(3'd3, 5'b01011, 4'h3, 4'h2, e);
    go_e0();
    wait_done(0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
